// File: rtl/serial_cla_sub.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit carry-lookahead stage, LSB nibble first.
// Operands shift right one nibble per RUN cycle; the result shifts in from the top.
module serial_cla_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NNIB = WIDTH / 4;
  localparam int NW   = $clog2(NNIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    nib_q, nib_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Nibble stage: A + ~B + carry with full 4-bit lookahead
  logic [3:0] nib_a, nib_nb, g, p, sum;
  logic [4:0] c;

  assign nib_a  = a_q[3:0];
  assign nib_nb = ~b_q[3:0];
  assign g      = nib_a & nib_nb;
  assign p      = nib_a ^ nib_nb;
  assign c[0]   = carry_q;
  assign c[1]   = g[0] | (p[0] & c[0]);
  assign c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sum
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          nib_d   = '0;
          carry_d = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        acc_d   = {sum, acc_q[WIDTH-1:4]};
        carry_d = c[4];
        nib_d   = nib_q + 1'b1;
        // Published results only move on the final nibble
        if (nib_q == NW'(NNIB - 1)) begin
          diff_d   = acc_d;
          borrow_d = ~c[4];
          ovf_d    = c[3] ^ c[4];
          zero_d   = (acc_d == '0);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      nib_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nib_q    <= nib_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule
